// File: rtl/dhs_apb_mst_arbiter.sv
// dhs_apb_mst_arbiter
//   Shares one APB master port between NUM_REQ requesters using round-robin
//   arbitration. Each requester presents one command over valid/ready. The
//   winner is run through APB SETUP/ACCESS, and the requester gets a one-cycle
//   response pulse carrying the read data and the error flag.
//
// Ports
//   clk_i, srst_i          clock, synchronous active-high reset
//   req_valid_i/ready_o    per-requester command handshake (ready only in IDLE)
//   req_write/addr/wdata/strb_i  packed per-requester command payloads
//   rsp_valid_o            one-cycle response pulse to the granted requester
//   rsp_rdata_o, rsp_err_o shared response payload, zero when no pulse
//   psel/penable/pwrite/paddr/pwdata/pstrb_o, pready/pslverr/prdata_i  APB
//
// Build option
//   DHS_APB_ARB_TIMEOUT_EN  ends ACCESS after TIMEOUT_CYC wait cycles and
//                           returns err=1, rdata=0.
module dhs_apb_mst_arbiter #(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic                          clk_i,
  input  logic                          srst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ-1:0]            req_write_i,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0]     req_wdata_i,
  input  logic [NUM_REQ*DATA_W/8-1:0]   req_strb_i,
  output logic [NUM_REQ-1:0]            rsp_valid_o,
  output logic [DATA_W-1:0]             rsp_rdata_o,
  output logic                          rsp_err_o,
  output logic                          psel_o,
  output logic                          penable_o,
  output logic                          pwrite_o,
  output logic [ADDR_W-1:0]             paddr_o,
  output logic [DATA_W-1:0]             pwdata_o,
  output logic [DATA_W/8-1:0]           pstrb_o,
  input  logic                          pready_i,
  input  logic                          pslverr_i,
  input  logic [DATA_W-1:0]             prdata_i
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]    gnt_q, gnt_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   strb_q, strb_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

`ifdef DHS_APB_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

  logic                gnt_found;
  logic [PTR_W-1:0]    gnt_idx;

  // Round-robin search: first valid requester at or after the pointer.
  always_comb begin
    int unsigned idx;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!gnt_found && req_valid_i[PTR_W'(idx)]) begin
        gnt_found = 1'b1;
        gnt_idx   = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    strb_d      = strb_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
`ifdef DHS_APB_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    req_ready_o = '0;
    rsp_valid_o = '0;
    rsp_rdata_o = '0;
    rsp_err_o   = 1'b0;
    psel_o      = 1'b0;
    penable_o   = 1'b0;
    pwrite_o    = 1'b0;
    paddr_o     = '0;
    pwdata_o    = '0;
    pstrb_o     = '0;

    unique case (state_q)
      IDLE: begin
        // Ready is held off during reset so every output reads zero.
        if (gnt_found && !srst_i) begin
          req_ready_o[gnt_idx] = 1'b1;
          gnt_d   = gnt_idx;
          wr_d    = req_write_i[gnt_idx];
          addr_d  = req_addr_i[gnt_idx*ADDR_W +: ADDR_W];
          wdata_d = req_wdata_i[gnt_idx*DATA_W +: DATA_W];
          strb_d  = req_write_i[gnt_idx] ? req_strb_i[gnt_idx*STRB_W +: STRB_W] : '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        psel_o   = 1'b1;
        pwrite_o = wr_q;
        paddr_o  = addr_q;
        pwdata_o = wdata_q;
        pstrb_o  = strb_q;
`ifdef DHS_APB_ARB_TIMEOUT_EN
        cnt_d    = '0;
`endif
        state_d  = ACCESS;
      end
      ACCESS: begin
        psel_o    = 1'b1;
        penable_o = 1'b1;
        pwrite_o  = wr_q;
        paddr_o   = addr_q;
        pwdata_o  = wdata_q;
        pstrb_o   = strb_q;
        if (pready_i) begin
          rdata_d = wr_q ? '0 : prdata_i;
          err_d   = pslverr_i;
          state_d = RESP;
        end
`ifdef DHS_APB_ARB_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
`endif
      end
      RESP: begin
        rsp_valid_o[gnt_q] = 1'b1;
        rsp_rdata_o        = rdata_q;
        rsp_err_o          = err_q;
        ptr_d   = (32'(gnt_q) == NUM_REQ - 1) ? '0 : gnt_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef DHS_APB_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef DHS_APB_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule

// File: doc/dhs_apb_mst_arbiter.md
Name: dhs_apb_mst_arbiter

Overview:
- Shares the single SoC APB slave port (apb_slv_req_i / apb_slv_resp_o) between NUM_REQ internal requesters, for example the boot loader, debug bridge and bench driver.
- Each requester issues one command at a time over a valid/ready interface and receives a one-cycle response pulse.
- Round-robin arbitration.
- Generates the APB SETUP/ACCESS sequence and returns prdata and pslverr to the winning requester.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 32, APB address width.
- DATA_W, 32, APB data width; strobe width is DATA_W/8.
- TIMEOUT_CYC, 256, ACCESS-phase cycle limit. Used only with DHS_APB_ARB_TIMEOUT_EN.

Ports:
- clk_i  in  1  block clock; also clocks the APB port.
- srst_i  in  1  reset, synchronous, active-high.
- req_valid_i  in  NUM_REQ  per-requester command valid.
- req_ready_o  out  NUM_REQ  per-requester command accept.
- req_write_i  in  NUM_REQ  1 = write, 0 = read.
- req_addr_i  in  NUM_REQ*ADDR_W  packed addresses; requester k at bits [k*ADDR_W +: ADDR_W].
- req_wdata_i  in  NUM_REQ*DATA_W  packed write data.
- req_strb_i  in  NUM_REQ*DATA_W/8  packed write strobes.
- rsp_valid_o  out  NUM_REQ  one-cycle response pulse to the granted requester.
- rsp_rdata_o  out  DATA_W  shared read data; valid when any rsp_valid_o bit is 1.
- rsp_err_o  out  1  shared error flag; valid with rsp_valid_o.
- psel_o, penable_o, pwrite_o  out  1 each  APB controls.
- paddr_o  out  ADDR_W  APB address.
- pwdata_o  out  DATA_W  APB write data.
- pstrb_o  out  DATA_W/8  APB write strobes.
- pready_i, pslverr_i  in  1 each  APB responses.
- prdata_i  in  DATA_W  APB read data.

Behaviour:
- Reset: srst_i sampled at posedge clk_i. The following are all 0 on the cycle after srst_i is asserted, and stay 0 while it is held:
  - every output;
  - FSM state (IDLE);
  - round-robin pointer;
  - timeout counter.
- Reset in mid-transfer: the transfer is abandoned and no rsp_valid_o is issued.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - Grant g is the first asserted req_valid_i index at or after the pointer, searching upward with wrap from NUM_REQ-1 to 0.
  - req_ready_o[g] = 1, combinational, only in IDLE and only for g. All other ready bits are 0.
  - On the handshake, capture write, addr, wdata and strb of g, then go to SETUP.
  - With no valid requester, stay in IDLE.
- SETUP (1 cycle):
  - psel_o=1, penable_o=0.
  - paddr_o, pwrite_o, pwdata_o, pstrb_o driven from the captured registers.
  - Go to ACCESS.
- ACCESS:
  - psel_o=1, penable_o=1; address, control and data held stable.
  - On pready_i=1: capture prdata_i (forced to 0 for writes) and pslverr_i, then go to RESP.
- RESP (1 cycle):
  - psel_o=0, penable_o=0.
  - rsp_valid_o[g]=1; rsp_rdata_o and rsp_err_o show the captured values.
  - Pointer set to (g+1) mod NUM_REQ; go to IDLE.
  - No response backpressure: requesters must accept the pulse.
- Output values outside the active phases:
  - rsp_rdata_o and rsp_err_o are 0 whenever rsp_valid_o == 0.
  - pstrb_o = 0 on reads.
  - All APB outputs are 0 in IDLE.
- Latency: handshake at cycle N, SETUP at N+1, ACCESS at N+2. With pready_i=1 at N+2, rsp_valid_o is asserted at N+3. The next handshake is possible at N+4, so one transfer completes every 4 cycles minimum.
- Simultaneous requests: strict round-robin. With all requesters held valid, grants cycle 0,1,…,NUM_REQ-1,0.
- Input change after grant: req_* changes after the handshake have no effect on the transfer in flight.
- Requester contract: a requester holds req_valid_i and its payload until ready. Dropping valid before ready is legal; the command is simply not issued.

Optional Feature:
- Macro: DHS_APB_ARB_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with pready_i=0.
  - When it reaches TIMEOUT_CYC, the next state is RESP with captured rdata=0 and err=1.
  - psel_o and penable_o drop to 0 in that RESP cycle. A late pready_i is ignored.
- When undefined: no counter; ACCESS waits indefinitely for pready_i.

Test Plan:
- Read with zero wait states: requester 0 reads addr 0x8000_0000, pready_i=1 in the first ACCESS cycle, prdata_i=0x0000_0001 -> psel_o 1 for 2 cycles, penable_o 1 for 1 cycle; rsp_valid_o=2'b01 three cycles after the handshake; rsp_rdata_o=0x0000_0001; rsp_err_o=0.
- Write with waits: requester 1 writes 0xDEAD_BEEF with strb 0xF, pready_i delayed 3 cycles -> paddr_o, pwdata_o and pstrb_o stable for all 4 ACCESS cycles; rsp_valid_o=2'b10; rsp_rdata_o=0; rsp_err_o=0.
- Contention: both requesters held valid for 4 commands each -> grant order 0,1,0,1,0,1,0,1; 8 responses; no command lost or duplicated.
- Error: pslverr_i=1 with pready_i on a read -> rsp_err_o=1 in the RESP cycle; the following transfer reports rsp_err_o=0.
- Reset mid-ACCESS: srst_i asserted during the second wait cycle -> all outputs 0 on the next cycle, no rsp_valid_o; after release, the next grant goes to requester 0.
- Timeout (DHS_APB_ARB_TIMEOUT_EN, TIMEOUT_CYC=8): pready_i held 0 -> rsp_valid_o after 8 ACCESS cycles with rsp_err_o=1 and rsp_rdata_o=0; psel_o=0 in the RESP cycle. Without the macro, the block is still in ACCESS after 1000 cycles.
